// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000-style bus-cycle initiator: FSM state
// encoding, transfer-size encoding, the I/O output-port address and the
// byte-lane helper functions.
package m68k_bus_pkg;

    // Initiator FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_TERM    = 3'd3,
        ST_BERR_S  = 3'd4,
        ST_RECOVER = 3'd5
    } bus_state_e;

    localparam int unsigned NUM_STATES = 6;

    // Transfer size as carried on REQ_BYTE_IN
    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    // Byte address of the responder's output port
    localparam logic [23:0] IO_OUTPUT_ADDR = 24'h100001;

    // A word access must be even-aligned
    function automatic logic is_misaligned(input logic size, input logic a0);
        is_misaligned = (size == SIZE_WORD) && (a0 == 1'b1);
    endfunction

    // Data strobes {UDS, LDS}: even byte lives on the upper lane
    function automatic logic [1:0] lane_strobes(input logic size, input logic a0);
        if (size == SIZE_WORD) begin
            lane_strobes = 2'b11;
        end else if (a0 == 1'b0) begin
            lane_strobes = 2'b10;
        end else begin
            lane_strobes = 2'b01;
        end
    endfunction

    // Byte writes replicate the byte onto both lanes so either strobe sees it
    function automatic logic [15:0] write_lanes(input logic size, input logic [15:0] wdata);
        if (size == SIZE_WORD) begin
            write_lanes = wdata;
        end else begin
            write_lanes = {wdata[7:0], wdata[7:0]};
        end
    endfunction

    // Byte reads are returned right-justified and zero-extended
    function automatic logic [15:0] read_lanes(input logic size, input logic a0,
                                               input logic [15:0] din);
        if (size == SIZE_WORD) begin
            read_lanes = din;
        end else if (a0 == 1'b0) begin
            read_lanes = {8'h00, din[15:8]};
        end else begin
            read_lanes = {8'h00, din[7:0]};
        end
    endfunction

endpackage

// File: rtl/m68k_bus_initiator_if.sv
// Request/acknowledge and bus-cycle signals of the initiator. The master
// modport is the initiator's view; the slave modport is the view of the
// requester plus bus responder that surrounds it.
interface m68k_bus_initiator_if #(
    parameter int ADDR_W = 24
) ();

    logic              REQ_IN;
    logic              REQ_WR_IN;
    logic              REQ_BYTE_IN;
    logic [ADDR_W-1:0] REQ_ADDR_IN;
    logic [15:0]       REQ_WDATA_IN;
    logic              BUSY;
    logic              DONE;
    logic              BERR;
    logic [15:0]       RDATA;
    logic              AS;
    logic              WR;
    logic              UDS;
    logic              LDS;
    logic [ADDR_W-1:0] ADDR;
    logic [15:0]       DATA_OUT;
    logic              DATA_OE;
    logic [15:0]       DATA_IN;
    logic              DTACK_IN;

    modport master (
        input  REQ_IN, REQ_WR_IN, REQ_BYTE_IN, REQ_ADDR_IN, REQ_WDATA_IN,
        input  DATA_IN, DTACK_IN,
        output BUSY, DONE, BERR, RDATA,
        output AS, WR, UDS, LDS, ADDR, DATA_OUT, DATA_OE
    );

    modport slave (
        output REQ_IN, REQ_WR_IN, REQ_BYTE_IN, REQ_ADDR_IN, REQ_WDATA_IN,
        output DATA_IN, DTACK_IN,
        input  BUSY, DONE, BERR, RDATA,
        input  AS, WR, UDS, LDS, ADDR, DATA_OUT, DATA_OE
    );

endinterface

// File: rtl/bus_timeout_counter.sv
// 8-bit saturating cycle counter used to bound the DTACK wait and the
// DTACK-release wait. expire flags the last permitted cycle.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic CPUCLK_IN,
    input  logic RESET_N_IN,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [7:0] LIMIT_C = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_r;

    // Count enabled cycles; clear wins over count, and the count sticks at the top
    always_ff @(posedge CPUCLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            count_r <= 8'd0;
        end else if (clr) begin
            count_r <= 8'd0;
        end else if (en && (count_r != 8'hFF)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (count_r == LIMIT_C);

endmodule

// File: rtl/m68k_bus_initiator.sv
// 68000-style bus-cycle initiator: turns a request into an AS/UDS/LDS bus
// cycle, waits (bounded) for DTACK, reports DONE or BERR, then waits for the
// responder to release DTACK before accepting the next request.
module m68k_bus_initiator
    import m68k_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 24
) (
    input  logic                 CPUCLK_IN,
    input  logic                 RESET_N_IN,
    m68k_bus_initiator_if.master bus
);

    bus_state_e        state_r, state_nxt_s;

    logic              busy_r, busy_nxt_s;
    logic              done_r, done_nxt_s;
    logic              berr_r, berr_nxt_s;
    logic [15:0]       rdata_r, rdata_nxt_s;
    logic              as_r, as_nxt_s;
    logic              uds_r, uds_nxt_s;
    logic              lds_r, lds_nxt_s;
    logic              wr_r, wr_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [15:0]       data_out_r, data_out_nxt_s;
    logic              data_oe_r, data_oe_nxt_s;
    logic              size_r, size_nxt_s;
    logic              a0_r, a0_nxt_s;

    logic              cnt_clr_s;
    logic              cnt_en_s;
    logic              cnt_expire_s;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .CPUCLK_IN (CPUCLK_IN),
        .RESET_N_IN(RESET_N_IN),
        .clr       (cnt_clr_s),
        .en        (cnt_en_s),
        .expire    (cnt_expire_s)
    );

    // Next state and next values of every registered output
    always_comb begin
        state_nxt_s    = state_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        berr_nxt_s     = 1'b0;
        rdata_nxt_s    = rdata_r;
        as_nxt_s       = 1'b0;
        uds_nxt_s      = 1'b0;
        lds_nxt_s      = 1'b0;
        wr_nxt_s       = wr_r;
        addr_nxt_s     = addr_r;
        data_out_nxt_s = data_out_r;
        data_oe_nxt_s  = 1'b0;
        size_nxt_s     = size_r;
        a0_nxt_s       = a0_r;
        cnt_clr_s      = 1'b0;
        cnt_en_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
                // DTACK still high means the responder has not let go of the last cycle
                if (bus.REQ_IN && !bus.DTACK_IN) begin
                    busy_nxt_s = 1'b1;
                    if (is_misaligned(bus.REQ_BYTE_IN, bus.REQ_ADDR_IN[0])) begin
                        // Rejected without touching the bus
                        state_nxt_s = ST_BERR_S;
                        berr_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s    = ST_ADDR;
                        wr_nxt_s       = bus.REQ_WR_IN;
                        size_nxt_s     = bus.REQ_BYTE_IN;
                        a0_nxt_s       = bus.REQ_ADDR_IN[0];
                        addr_nxt_s     = {bus.REQ_ADDR_IN[ADDR_W-1:1],
                                          bus.REQ_ADDR_IN[0] & (bus.REQ_BYTE_IN == SIZE_BYTE)};
                        data_out_nxt_s = write_lanes(bus.REQ_BYTE_IN, bus.REQ_WDATA_IN);
                        data_oe_nxt_s  = bus.REQ_WR_IN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_ADDR: begin
                cnt_clr_s                = 1'b1;
                state_nxt_s              = ST_WAIT;
                as_nxt_s                 = 1'b1;
                {uds_nxt_s, lds_nxt_s}   = lane_strobes(size_r, a0_r);
                data_oe_nxt_s            = wr_r;
            end

            ST_WAIT: begin
                // DTACK is checked first so it wins over a simultaneous timeout
                if (bus.DTACK_IN) begin
                    state_nxt_s = ST_TERM;
                    done_nxt_s  = 1'b1;
                    if (!wr_r) begin
                        rdata_nxt_s = read_lanes(size_r, a0_r, bus.DATA_IN);
                    end else begin
                        rdata_nxt_s = rdata_r;
                    end
                end else if (cnt_expire_s) begin
                    state_nxt_s = ST_BERR_S;
                    berr_nxt_s  = 1'b1;
                end else begin
                    cnt_en_s               = 1'b1;
                    state_nxt_s            = ST_WAIT;
                    as_nxt_s               = 1'b1;
                    {uds_nxt_s, lds_nxt_s} = lane_strobes(size_r, a0_r);
                    data_oe_nxt_s          = wr_r;
                end
            end

            ST_TERM: begin
                cnt_clr_s   = 1'b1;
                state_nxt_s = ST_RECOVER;
            end

            ST_BERR_S: begin
                cnt_clr_s   = 1'b1;
                state_nxt_s = ST_RECOVER;
            end

            ST_RECOVER: begin
                if (!bus.DTACK_IN) begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                end else if (cnt_expire_s) begin
                    // Responder never released DTACK: give up and flag it
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                    berr_nxt_s  = 1'b1;
                end else begin
                    cnt_en_s    = 1'b1;
                    state_nxt_s = ST_RECOVER;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops everything, strobes included, at once
    always_ff @(posedge CPUCLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            berr_r     <= 1'b0;
            rdata_r    <= 16'h0000;
            as_r       <= 1'b0;
            uds_r      <= 1'b0;
            lds_r      <= 1'b0;
            wr_r       <= 1'b0;
            addr_r     <= '0;
            data_out_r <= 16'h0000;
            data_oe_r  <= 1'b0;
            size_r     <= SIZE_WORD;
            a0_r       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            berr_r     <= berr_nxt_s;
            rdata_r    <= rdata_nxt_s;
            as_r       <= as_nxt_s;
            uds_r      <= uds_nxt_s;
            lds_r      <= lds_nxt_s;
            wr_r       <= wr_nxt_s;
            addr_r     <= addr_nxt_s;
            data_out_r <= data_out_nxt_s;
            data_oe_r  <= data_oe_nxt_s;
            size_r     <= size_nxt_s;
            a0_r       <= a0_nxt_s;
        end
    end

    assign bus.BUSY     = busy_r;
    assign bus.DONE     = done_r;
    assign bus.BERR     = berr_r;
    assign bus.RDATA    = rdata_r;
    assign bus.AS       = as_r;
    assign bus.WR       = wr_r;
    assign bus.UDS      = uds_r;
    assign bus.LDS      = lds_r;
    assign bus.ADDR     = addr_r;
    assign bus.DATA_OUT = data_out_r;
    assign bus.DATA_OE  = data_oe_r;

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Directed bench for m68k_bus_initiator: a delay-programmable DTACK
// responder, a transaction-level expectation model checked every cycle, and
// hand-computed latency/data expectations per transaction.
module tb_m68k_bus_initiator;
    import m68k_bus_pkg::*;

    localparam int T_C = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    m68k_bus_initiator_if #(.ADDR_W(24)) bus_if ();

    m68k_bus_initiator #(.TIMEOUT_CYCLES(T_C), .ADDR_W(24)) dut (
        .CPUCLK_IN (clk),
        .RESET_N_IN(rst_n),
        .bus       (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- responder ----------------
    logic        resp_en     = 1'b0;
    int unsigned resp_delay  = 1;
    int unsigned as_run      = 0;
    logic        dtack_r     = 1'b0;
    logic        dtack_force = 1'b0;
    logic [7:0]  out_sig     = 8'h00;
    logic [15:0] din_v       = 16'h0000;

    assign bus_if.DTACK_IN = dtack_r | dtack_force;
    assign bus_if.DATA_IN  = din_v;

    always @(posedge clk) begin
        if (bus_if.AS && resp_en) begin
            as_run  <= as_run + 1;
            dtack_r <= ((as_run + 1) >= resp_delay);
        end else begin
            as_run  <= 0;
            dtack_r <= 1'b0;
        end
        if (bus_if.AS && bus_if.WR && bus_if.LDS && !dtack_r && (bus_if.ADDR == IO_OUTPUT_ADDR))
            out_sig <= bus_if.DATA_OUT[7:0];
    end

    // ---------------- expectation model ----------------
    logic        cmp_on   = 1'b0;
    logic        cur_wr   = 1'b0;
    logic        cur_byte = 1'b0;
    logic [23:0] cur_addr = 24'h0;
    logic [15:0] cur_wd   = 16'h0;
    logic        cur_mis  = 1'b0;

    function automatic logic [1:0] m_lanes(input logic b, input logic [23:0] a);
        if (!b) return 2'b11;
        return (a % 2 == 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [23:0] m_addr(input logic b, input logic [23:0] a);
        return b ? a : (a & 24'hFFFFFE);
    endfunction

    function automatic logic [15:0] m_wdata(input logic b, input logic [15:0] w);
        return b ? 16'((w & 16'h00FF) * 16'h0101) : w;
    endfunction

    function automatic logic [15:0] m_rdata(input logic b, input logic [23:0] a, input logic [15:0] d);
        if (!b) return d;
        return (a % 2 == 0) ? (d >> 8) : (d & 16'h00FF);
    endfunction

    // Per-cycle comparison of bus outputs against the current transaction
    always @(negedge clk) begin
        if (cmp_on) begin
            if (cur_mis) begin
                chk("mis_no_strobes", 32'({bus_if.AS, bus_if.UDS, bus_if.LDS}), 32'd0);
            end else if (bus_if.AS) begin
                chk("lanes", 32'({bus_if.UDS, bus_if.LDS}), 32'(m_lanes(cur_byte, cur_addr)));
                chk("addr", 32'(bus_if.ADDR), 32'(m_addr(cur_byte, cur_addr)));
                chk("wr", 32'(bus_if.WR), 32'(cur_wr));
                chk("data_oe", 32'(bus_if.DATA_OE), 32'(cur_wr));
                if (cur_wr) chk("data_out", 32'(bus_if.DATA_OUT), 32'(m_wdata(cur_byte, cur_wd)));
            end else begin
                chk("ds_without_as", 32'({bus_if.UDS, bus_if.LDS}), 32'd0);
            end
            if (bus_if.DONE && !cur_wr)
                chk("rdata_model", 32'(bus_if.RDATA), 32'(m_rdata(cur_byte, cur_addr, din_v)));
            chk("done_berr_excl", 32'(bus_if.DONE & bus_if.BERR), 32'd0);
        end
    end

    // ---------------- transaction driver ----------------
    int   r_done_cnt, r_done_at, r_berr_cnt, r_berr_at, r_as_cnt, r_as_first, r_busy_low;
    logic [1:0] r_lanes;
    logic       r_oe;

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((bus_if.BUSY || bus_if.DTACK_IN) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_reached", 32'(guard < 100), 32'd1);
    endtask

    // Index k: outputs seen at the negedge after accept edge t+k-1 (k=1 right after accept)
    task automatic do_txn(input logic wr, input logic byt, input logic [23:0] a,
                          input logic [15:0] wd, input logic [15:0] din,
                          input int unsigned delay, input logic en, input int force_len);
        int fcnt = 0;
        wait_idle();
        resp_en = en; resp_delay = delay; din_v = din;
        cur_wr = wr; cur_byte = byt; cur_addr = a; cur_wd = wd; cur_mis = !byt && a[0];
        r_done_cnt = 0; r_done_at = 0; r_berr_cnt = 0; r_berr_at = 0;
        r_as_cnt = 0; r_as_first = 0; r_busy_low = 0; r_lanes = 2'b00; r_oe = 1'b0;
        bus_if.REQ_IN = 1'b1; bus_if.REQ_WR_IN = wr; bus_if.REQ_BYTE_IN = byt;
        bus_if.REQ_ADDR_IN = a; bus_if.REQ_WDATA_IN = wd;
        cmp_on = 1'b1;
        @(negedge clk);
        bus_if.REQ_IN = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            if (bus_if.DONE) begin r_done_cnt++; r_done_at = k; end
            if (bus_if.BERR) begin r_berr_cnt++; r_berr_at = k; end
            if (bus_if.AS) begin
                r_as_cnt++;
                if (r_as_first == 0) r_as_first = k;
            end
            r_lanes = r_lanes | {bus_if.UDS, bus_if.LDS};
            r_oe    = r_oe | bus_if.DATA_OE;
            if (bus_if.DONE && force_len > 0) begin
                dtack_force = 1'b1;
                fcnt = force_len;
            end else if (fcnt > 0) begin
                fcnt--;
                if (fcnt == 0) dtack_force = 1'b0;
            end
            if (!bus_if.BUSY) begin
                r_busy_low = k;
                break;
            end
            @(negedge clk);
        end
        dtack_force = 1'b0;
        cmp_on = 1'b0;
        chk("busy_fell_in_budget", 32'(r_busy_low != 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.REQ_IN = 1'b0; bus_if.REQ_WR_IN = 1'b0; bus_if.REQ_BYTE_IN = 1'b0;
        bus_if.REQ_ADDR_IN = 24'h0; bus_if.REQ_WDATA_IN = 16'h0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_ctrl", 32'({bus_if.BUSY, bus_if.DONE, bus_if.BERR, bus_if.AS, bus_if.WR,
                             bus_if.UDS, bus_if.LDS, bus_if.DATA_OE}), 32'd0);
        chk("rst_rdata", 32'(bus_if.RDATA), 32'd0);
        chk("rst_addr", 32'(bus_if.ADDR), 32'd0);
        chk("rst_data_out", 32'(bus_if.DATA_OUT), 32'd0);
        rst_n = 1'b1;

        // Word read 0x000100
        do_txn(1'b0, 1'b0, 24'h000100, 16'h0000, 16'hBEEF, 1, 1'b1, 0);
        chk("wr1_as_first", 32'(r_as_first), 32'd2);
        chk("wr1_done_at", 32'(r_done_at), 32'd4);
        chk("wr1_busy_low", 32'(r_busy_low), 32'd6);
        chk("wr1_lanes", 32'(r_lanes), 32'h3);
        chk("wr1_berr", 32'(r_berr_cnt), 32'd0);
        chk("wr1_rdata", 32'(bus_if.RDATA), 32'hBEEF);

        // Byte write to the output port
        do_txn(1'b1, 1'b1, 24'h100001, 16'hA55A, 16'h0000, 1, 1'b1, 0);
        chk("bw_lanes", 32'(r_lanes), 32'h1);
        chk("bw_oe", 32'(r_oe), 32'd1);
        chk("bw_done_at", 32'(r_done_at), 32'd4);
        chk("bw_data_out", 32'(bus_if.DATA_OUT), 32'h5A5A);
        chk("bw_out_sig", 32'(out_sig), 32'h5A);
        chk("bw_rdata_kept", 32'(bus_if.RDATA), 32'hBEEF);

        // Byte read even / odd
        do_txn(1'b0, 1'b1, 24'h000000, 16'h0000, 16'h1234, 1, 1'b1, 0);
        chk("bre_lanes", 32'(r_lanes), 32'h2);
        chk("bre_rdata", 32'(bus_if.RDATA), 32'h0012);
        do_txn(1'b0, 1'b1, 24'h000201, 16'h0000, 16'h1234, 1, 1'b1, 0);
        chk("bro_lanes", 32'(r_lanes), 32'h1);
        chk("bro_rdata", 32'(bus_if.RDATA), 32'h0034);

        // No DTACK at all: timeout
        do_txn(1'b0, 1'b0, 24'h000200, 16'h0000, 16'hFFFF, 1, 1'b0, 0);
        chk("to_as_cnt", 32'(r_as_cnt), 32'd16);
        chk("to_berr_cnt", 32'(r_berr_cnt), 32'd1);
        chk("to_berr_at", 32'(r_berr_at), 32'd18);
        chk("to_done_cnt", 32'(r_done_cnt), 32'd0);
        chk("to_busy_low", 32'(r_busy_low), 32'd20);
        chk("to_rdata_kept", 32'(bus_if.RDATA), 32'h0034);

        // DTACK arrives on the last permitted cycle: DTACK wins
        do_txn(1'b0, 1'b0, 24'h000300, 16'h0000, 16'hCAFE, 15, 1'b1, 0);
        chk("edge_as_cnt", 32'(r_as_cnt), 32'd16);
        chk("edge_done_at", 32'(r_done_at), 32'd18);
        chk("edge_berr", 32'(r_berr_cnt), 32'd0);
        chk("edge_rdata", 32'(bus_if.RDATA), 32'hCAFE);

        // Misaligned word
        do_txn(1'b0, 1'b0, 24'h000003, 16'h0000, 16'h0000, 1, 1'b1, 0);
        chk("mis_berr_at", 32'(r_berr_at), 32'd1);
        chk("mis_berr_cnt", 32'(r_berr_cnt), 32'd1);
        chk("mis_as_cnt", 32'(r_as_cnt), 32'd0);
        chk("mis_lanes", 32'(r_lanes), 32'd0);
        chk("mis_done", 32'(r_done_cnt), 32'd0);
        chk("mis_busy_low", 32'(r_busy_low), 32'd3);

        // Word write
        do_txn(1'b1, 1'b0, 24'h000400, 16'h1357, 16'h0000, 1, 1'b1, 0);
        chk("ww_lanes", 32'(r_lanes), 32'h3);
        chk("ww_done_at", 32'(r_done_at), 32'd4);
        chk("ww_data_out", 32'(bus_if.DATA_OUT), 32'h1357);

        // DTACK held 3 cycles after TERM
        do_txn(1'b0, 1'b0, 24'h000500, 16'h0000, 16'h0F0F, 1, 1'b1, 3);
        chk("hold_done_at", 32'(r_done_at), 32'd4);
        chk("hold_busy_low", 32'(r_busy_low), 32'd8);
        chk("hold_berr", 32'(r_berr_cnt), 32'd0);

        // DTACK stuck high past the limit
        do_txn(1'b0, 1'b0, 24'h000600, 16'h0000, 16'h00AA, 1, 1'b1, 20);
        chk("stuck_done_cnt", 32'(r_done_cnt), 32'd1);
        chk("stuck_berr_cnt", 32'(r_berr_cnt), 32'd1);
        chk("stuck_berr_at", 32'(r_berr_at), 32'd21);
        chk("stuck_busy_low", 32'(r_busy_low), 32'd21);

        // Reset in the middle of WAIT
        wait_idle();
        resp_en = 1'b0;
        bus_if.REQ_IN = 1'b1; bus_if.REQ_WR_IN = 1'b0; bus_if.REQ_BYTE_IN = 1'b0;
        bus_if.REQ_ADDR_IN = 24'h000700;
        @(negedge clk);
        bus_if.REQ_IN = 1'b0;
        for (int g = 0; g < 10 && !bus_if.AS; g++) @(negedge clk);
        chk("rw_as_before_reset", 32'(bus_if.AS), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_strobes_dropped", 32'({bus_if.AS, bus_if.UDS, bus_if.LDS, bus_if.BUSY}), 32'd0);
        chk("rw_no_pulse", 32'({bus_if.DONE, bus_if.BERR}), 32'd0);
        chk("rw_rdata_reset", 32'(bus_if.RDATA), 32'd0);
        @(negedge clk);
        chk("rw_no_pulse_held", 32'({bus_if.DONE, bus_if.BERR, bus_if.AS}), 32'd0);
        rst_n = 1'b1;
        do_txn(1'b0, 1'b0, 24'h000800, 16'h0000, 16'h7E81, 1, 1'b1, 0);
        chk("rw_after_done_at", 32'(r_done_at), 32'd4);
        chk("rw_after_rdata", 32'(bus_if.RDATA), 32'h7E81);
        chk("rw_after_busy_low", 32'(r_busy_low), 32'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/m68k_bus_initiator.md
Name: m68k_bus_initiator

Overview:
- Synchronous 68000-style bus-cycle initiator. It turns a simple request/acknowledge interface into AS/UDS/LDS/WR/address/data bus cycles and waits for DTACK from the board's bus responder.
- Bus strobes are active-high, matching the FPGA-internal convention of the responder side.
- Used as a DMA/test master that shares the bus-responder interface, and as the bus-cycle driver for bench-level exercising of the chip-select/DTACK logic.
- Bounded DTACK wait, with a bus-error indication on timeout.

Parameters:
TIMEOUT_CYCLES, 16, CPUCLK_IN cycles allowed in WAIT or RECOVER before bus error (legal range 2..255)
ADDR_W, 24, bus address width

Ports:
CPUCLK_IN  input  1  clock, all state on rising edge
RESET_N_IN  input  1  asynchronous, active-low reset
REQ_IN  input  1  request valid; sampled only when BUSY=0
REQ_WR_IN  input  1  1=write, 0=read
REQ_BYTE_IN  input  1  1=byte access, 0=word access
REQ_ADDR_IN  input  ADDR_W  byte address
REQ_WDATA_IN  input  16  write data; byte writes use [7:0]
BUSY  output  1  high from accept until return to IDLE
DONE  output  1  one-cycle pulse: cycle terminated by DTACK
BERR  output  1  one-cycle pulse: timeout or misaligned word
RDATA  output  16  read data, valid from DONE onward until next accept
AS  output  1  address strobe
WR  output  1  write direction
UDS  output  1  upper (even) byte strobe
LDS  output  1  lower (odd) byte strobe
ADDR  output  ADDR_W  bus address
DATA_OUT  output  16  write data to bus
DATA_OE  output  1  drive enable for DATA_OUT
DATA_IN  input  16  read data from bus
DTACK_IN  input  1  data acknowledge (same clock domain, no synchronizer)

Behaviour:
Reset and outputs:
- On RESET_N_IN low, immediately and at any time: state=IDLE, timeout counter=0.
- Reset values: all outputs 0, RDATA=0.
- Reset mid-cycle drops the strobes at once. No DONE or BERR pulse is generated.
- All outputs are registered.

States: IDLE, ADDR, WAIT, TERM, BERR_S, RECOVER.

IDLE:
- Accept when REQ_IN=1 and DTACK_IN=0. Capture request fields; BUSY=1 next cycle.
- Misaligned word request (REQ_BYTE_IN=0, REQ_ADDR_IN[0]=1): go to BERR_S with no bus activity. AS and DS stay 0.
- Otherwise go to ADDR.

ADDR (1 cycle):
- ADDR is driven with REQ_ADDR and bit 0 forced to 0 for words; WR is driven.
- For writes, DATA_OE=1 and DATA_OUT is driven.
- Write data: word = WDATA. Byte = {WDATA[7:0], WDATA[7:0]} (replicated on both lanes).

WAIT:
- AS=1, plus data strobes: word → UDS=LDS=1; byte at addr[0]=0 → UDS only; byte at addr[0]=1 → LDS only.
- Counter is cleared on entry and increments each cycle without DTACK.
- DTACK_IN=1 sampled: for reads, RDATA ← word = DATA_IN; byte even = {8'h00, DATA_IN[15:8]}; byte odd = {8'h00, DATA_IN[7:0]}. Then go to TERM.
- Counter reaches TIMEOUT_CYCLES-1 with DTACK_IN=0: go to BERR_S.
- DTACK and timeout in the same cycle: DTACK wins.

TERM (1 cycle): AS/UDS/LDS/DATA_OE=0, DONE=1. Then RECOVER.

BERR_S (1 cycle): AS/UDS/LDS/DATA_OE=0, BERR=1. Then RECOVER.

RECOVER:
- Waits for DTACK_IN=0, then goes to IDLE with BUSY=0.
- If DTACK is stuck high for TIMEOUT_CYCLES cycles, go to IDLE anyway and pulse BERR.

Address and direction hold:
- ADDR, WR and DATA_OUT stay stable from ADDR through TERM/BERR_S.
- They hold their values in IDLE. Only the strobes return to 0.

Latency:
- Accept at edge t.
- AS is high during cycles t+2..; DTACK is sampled from t+2.
- With a responder that registers DTACK one clock after the strobes, DONE occurs at t+4.

Requests while BUSY=1 are ignored; the requester holds REQ_IN.

Decomposition:
- Shared package m68k_bus_pkg holds: state encoding (6 states, localparams), the size encoding constants, and the I/O output-port address 24'h100001 for bench use.
- Sub-module bus_timeout_counter: clear, enable, and expire at TIMEOUT_CYCLES-1; 8-bit saturating counter. It is used by WAIT and RECOVER.

Test Plan:
- Word read 0x000100, responder DTACK 1 cycle after AS, DATA_IN=16'hBEEF → UDS=LDS=1, WR=0, DONE at t+4, RDATA=16'hBEEF, BUSY low at t+6.
- Byte write 0x100001 data 8'h5A → LDS=1, UDS=0, WR=1, DATA_OUT=16'h5A5A, DATA_OE=1 during WAIT; responder OUTPUT_SIGNAL becomes 8'h5A.
- Byte read 0x000000 (even), DATA_IN=16'h12_34 → only UDS, RDATA=16'h0012.
- DTACK never asserted, TIMEOUT_CYCLES=16 → AS high exactly 16 cycles, BERR one pulse, no DONE, RDATA unchanged.
- Word request at 0x000003 → BERR at t+1, AS/UDS/LDS never high.
- Reset asserted during WAIT → AS/UDS/LDS/BUSY=0 immediately; after release a new read completes normally. Separately, hold DTACK_IN=1 after TERM for 3 cycles → BUSY stays 1 until DTACK drops.
